// File: rtl/toy_fetch_buf.sv
// Decoupled instruction fetch front-end: sequential word requests, in-order responses
// queued in a DEPTH-entry buffer, with branch-lock and redirect-with-flush.
module toy_fetch_buf #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INST_WIDTH  = 32,
    parameter int                    DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter bit                    BRANCH_LOCK = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req_vld,
    input  logic                  mem_req_rdy,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_vld,
    input  logic [INST_WIDTH-1:0] mem_rsp_data,
    input  logic                  pc_release_en,
    input  logic                  pc_update_en,
    input  logic [ADDR_WIDTH-1:0] pc_val,
    output logic                  instruction_vld,
    input  logic                  instruction_rdy,
    output logic [INST_WIDTH-1:0] instruction_pld,
    output logic [ADDR_WIDTH-1:0] instruction_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_rsp_pc;
    logic [CW-1:0]         r_out_cnt;
    logic [CW-1:0]         r_drop_cnt;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic                  r_lock;
    logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];

    logic          w_req_fire;
    logic          w_rsp_live;
    logic          w_drop;
    logic          w_enq;
    logic          w_deq;
    logic          w_is_br;
    logic [CW:0]   w_credit;
    logic [CW-1:0] w_out_nxt;
    logic [CW:0]   w_drop_sum;

    // Credits cover both in-flight requests and buffered entries, so an enqueue never overflows.
    assign w_credit     = {1'b0, r_out_cnt} + {1'b0, r_count};
    assign mem_req_vld  = ~rst & ~r_lock & ~pc_update_en & (w_credit < (CW+1)'(DEPTH));
    assign mem_req_addr = {2'b00, r_fetch_pc[ADDR_WIDTH-1:2]};
    assign w_req_fire   = mem_req_vld & mem_req_rdy;

    assign w_rsp_live = mem_rsp_vld & (r_out_cnt != '0);
    assign w_drop     = w_rsp_live & (r_drop_cnt != '0);
    assign w_enq      = w_rsp_live & ~w_drop;
    assign w_is_br    = BRANCH_LOCK && (mem_rsp_data[6:2] inside {OPC_JAL, OPC_JALR, OPC_BRANCH});
    assign w_deq      = instruction_vld & instruction_rdy;
    assign w_out_nxt  = r_out_cnt + CW'(w_req_fire) - CW'(w_rsp_live);
    assign w_drop_sum = {1'b0, r_drop_cnt} + {1'b0, r_out_cnt} - (CW+1)'(w_rsp_live);

    assign instruction_vld = (r_count != '0);
    assign instruction_pld = r_inst_mem[r_rd_ptr];
    assign instruction_pc  = r_pc_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_lock     <= 1'b0;
        end else begin
            r_out_cnt <= w_out_nxt;
            if (pc_update_en) begin
                // Everything still in flight belongs to the old path and must be discarded.
                r_fetch_pc <= pc_val;
                r_rsp_pc   <= pc_val;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_drop_cnt <= (w_drop_sum > {1'b0, w_out_nxt}) ? w_out_nxt : w_drop_sum[CW-1:0];
                r_lock     <= 1'b0;
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
                if (w_enq) begin
                    r_rsp_pc <= r_rsp_pc + ADDR_WIDTH'(4);
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
                r_count <= r_count + CW'(w_enq) - CW'(w_deq);
                if (w_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
                if (w_enq & w_is_br)    r_lock <= 1'b1;
                else if (pc_release_en) r_lock <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_inst_mem[r_wr_ptr] <= mem_rsp_data;
            r_pc_mem[r_wr_ptr]   <= r_rsp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_rsp_vld) assert (r_out_cnt != '0);
    end

endmodule
